// File: rtl/gpio_ext_pkg.sv
// Shared types and register offsets for the extended GPIO peripheral.
package gpio_ext_pkg;

    localparam int unsigned GPIO_EXT_MAX_PINS = 32;

    // Register offsets, decoded on addr[7:0]
    typedef enum logic [7:0] {
        RegDataIn  = 8'h00,
        RegDataOut = 8'h04,
        RegOutSet  = 8'h08,
        RegOutClr  = 8'h0C,
        RegOutTgl  = 8'h10,
        RegDir     = 8'h14,
        RegIe      = 8'h18,
        RegIp      = 8'h1C,
        RegIntType = 8'h20,
        RegIntPol  = 8'h24,
        RegIntBoth = 8'h28,
        RegDbEn    = 8'h2C,
        RegDbPresc = 8'h30
    } type_gpio_ext_regs_e;

    // Data bus request from the interconnect to a peripheral
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] w_data;
        logic        w_en;
        logic        req;
    } type_dbus2peri_s;

    // Data bus response from a peripheral
    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_peri2dbus_s;

    // Bus handshake states
    typedef enum logic {
        StIdle,
        StAck
    } type_gpio_bus_state_e;

endpackage

// File: rtl/gpio_in_filter.sv
// Input conditioning for all pins: synchroniser chain, shared debounce
// prescaler tick, and per-pin two-sample debounce filter.
module gpio_in_filter
    import gpio_ext_pkg::*;
#(
    parameter int unsigned NUM_PINS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_PRESC_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PINS-1:0]   pin_in,
    input  logic [NUM_PINS-1:0]   db_en,
    input  logic [DB_PRESC_W-1:0] db_presc,
    input  logic                  presc_restart,
    output logic [NUM_PINS-1:0]   filt
);

    logic [NUM_PINS-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0]   sync_val;
    logic [DB_PRESC_W-1:0] presc_q;
    logic                  tick;
    logic [NUM_PINS-1:0]   db_sample_q;
    logic [NUM_PINS-1:0]   db_filt_q;
    logic [NUM_PINS-1:0]   agree;

    assign sync_val = sync_q[SYNC_STAGES-1];
    // >= keeps the tick alive if DB_PRESC shrinks below the running count
    assign tick     = (presc_q >= db_presc);
    assign agree    = ~(sync_val ^ db_sample_q);

    // Synchroniser flop chain for the asynchronous pads
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Shared prescaler: tick once every db_presc+1 cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (presc_restart || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Debounce: a pin only moves when two consecutive tick samples agree
    always_ff @(posedge clk) begin
        if (rst) begin
            db_sample_q <= '0;
            db_filt_q   <= '0;
        end else if (tick) begin
            db_sample_q <= sync_val;
            db_filt_q   <= (agree & sync_val) | (~agree & db_filt_q);
        end
    end

    assign filt = (db_en & db_filt_q) | (~db_en & sync_val);

endmodule

// File: rtl/gpio_ext.sv
// Parametrised GPIO peripheral: register file, atomic output updates,
// level/edge interrupts and a two-state bus handshake.
module gpio_ext
    import gpio_ext_pkg::*;
#(
    parameter int unsigned NUM_PINS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_PRESC_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gpio_sel_i,
    input  type_dbus2peri_s     dbus2gpio_i,
    output type_peri2dbus_s     gpio2dbus_o,
    output logic                gpio_irq_o,
    input  logic [NUM_PINS-1:0] gpio_in_i,
    output logic [NUM_PINS-1:0] gpio_out_o,
    output logic [NUM_PINS-1:0] gpio_oe_o
);

    type_gpio_bus_state_e state_q, state_d;
    logic                  fire, wr, ack;
    logic [7:0]            addr_lo;
    logic [NUM_PINS-1:0]   wd;
    logic [31:0]           rd_val, r_data_q;

    logic [NUM_PINS-1:0]   data_out_q, dir_q, ie_q, ip_q, ip_d;
    logic [NUM_PINS-1:0]   int_type_q, int_pol_q, int_both_q, db_en_q;
    logic [DB_PRESC_W-1:0] db_presc_q;
    logic [NUM_PINS-1:0]   filt, prev_filt_q;
    logic [NUM_PINS-1:0]   rise, fall, edge_hit, ip_set, ip_w1c, level_hit;
    logic                  presc_restart;
    logic                  unused_bus;

    assign addr_lo       = dbus2gpio_i.addr[7:0];
    assign wd            = dbus2gpio_i.w_data[NUM_PINS-1:0];
    assign fire          = (state_q == StIdle) && gpio_sel_i && dbus2gpio_i.req;
    assign wr            = fire && dbus2gpio_i.w_en;
    assign presc_restart = wr && (addr_lo == RegDbPresc);
    assign unused_bus    = ^{dbus2gpio_i.addr[31:8], dbus2gpio_i.w_data};

    gpio_in_filter #(
        .NUM_PINS    (NUM_PINS),
        .SYNC_STAGES (SYNC_STAGES),
        .DB_PRESC_W  (DB_PRESC_W)
    ) u_in_filter (
        .clk           (clk),
        .rst           (rst),
        .pin_in        (gpio_in_i),
        .db_en         (db_en_q),
        .db_presc      (db_presc_q),
        .presc_restart (presc_restart),
        .filt          (filt)
    );

    // Bus FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus FSM next state: one ack cycle per accepted request
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fire) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus FSM outputs
    always_comb begin
        ack = (state_q == StAck);
    end

    // Read data mux; unused upper bits stay zero
    always_comb begin
        rd_val = '0;
        case (addr_lo)
            RegDataIn:  rd_val[NUM_PINS-1:0]   = filt;
            RegDataOut: rd_val[NUM_PINS-1:0]   = data_out_q;
            RegDir:     rd_val[NUM_PINS-1:0]   = dir_q;
            RegIe:      rd_val[NUM_PINS-1:0]   = ie_q;
            RegIp:      rd_val[NUM_PINS-1:0]   = ip_q;
            RegIntType: rd_val[NUM_PINS-1:0]   = int_type_q;
            RegIntPol:  rd_val[NUM_PINS-1:0]   = int_pol_q;
            RegIntBoth: rd_val[NUM_PINS-1:0]   = int_both_q;
            RegDbEn:    rd_val[NUM_PINS-1:0]   = db_en_q;
            RegDbPresc: rd_val[DB_PRESC_W-1:0] = db_presc_q;
            default:    rd_val = '0;
        endcase
    end

    // Registered read data, zero outside a read ack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= (fire && !dbus2gpio_i.w_en) ? rd_val : '0;
        end
    end

    // Software-visible configuration and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            dir_q      <= '0;
            ie_q       <= '0;
            int_type_q <= '0;
            int_pol_q  <= '0;
            int_both_q <= '0;
            db_en_q    <= '0;
            db_presc_q <= '0;
        end else if (wr) begin
            case (addr_lo)
                RegDataOut: data_out_q <= wd;
                RegOutSet:  data_out_q <= data_out_q | wd;
                RegOutClr:  data_out_q <= data_out_q & ~wd;
                RegOutTgl:  data_out_q <= data_out_q ^ wd;
                RegDir:     dir_q      <= wd;
                RegIe:      ie_q       <= wd;
                RegIntType: int_type_q <= wd;
                RegIntPol:  int_pol_q  <= wd;
                RegIntBoth: int_both_q <= wd;
                RegDbEn:    db_en_q    <= wd;
                RegDbPresc: db_presc_q <= dbus2gpio_i.w_data[DB_PRESC_W-1:0];
                default:    ;
            endcase
        end
    end

    // Interrupt pending: level pins follow the filtered input, edge pins are
    // sticky until W1C, and a same-cycle set beats the clear
    always_comb begin
        rise      = filt & ~prev_filt_q;
        fall      = ~filt & prev_filt_q;
        edge_hit  = (int_both_q & (rise | fall)) |
                    (~int_both_q & ((int_pol_q & rise) | (~int_pol_q & fall)));
        ip_set    = ~dir_q & int_type_q & edge_hit;
        ip_w1c    = (wr && (addr_lo == RegIp)) ? wd : '0;
        level_hit = ~dir_q & ~(filt ^ int_pol_q);
        ip_d      = (int_type_q & ((ip_q & ~ip_w1c) | ip_set)) | (~int_type_q & level_hit);
    end

    // Edge history and pending flags
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_filt_q <= '0;
            ip_q        <= '0;
        end else begin
            prev_filt_q <= filt;
            ip_q        <= ip_d;
        end
    end

    assign gpio2dbus_o.r_data = r_data_q;
    assign gpio2dbus_o.ack    = ack;
    assign gpio_irq_o         = |(ie_q & ip_q);
    assign gpio_out_o         = data_out_q;
    assign gpio_oe_o          = dir_q;

endmodule

// File: tb/tb_gpio_ext.sv
// Scoreboard bench for gpio_ext: register-level reference model, randomized
// bus/pin traffic and directed interrupt, debounce and handshake scenarios.
module tb_gpio_ext;
    import gpio_ext_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            sel;
    type_dbus2peri_s d2p;
    type_peri2dbus_s p2d;
    logic            irq;
    logic [15:0]     pins;
    logic [15:0]     gout, goe;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    // Reference model state (software view of the block)
    logic [15:0] m_out, m_dir, m_ie, m_ip, m_type, m_pol, m_both, m_db_en, m_presc, m_pins;

    gpio_ext #(
        .NUM_PINS    (16),
        .SYNC_STAGES (2),
        .DB_PRESC_W  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gpio_sel_i  (sel),
        .dbus2gpio_i (d2p),
        .gpio2dbus_o (p2d),
        .gpio_irq_o  (irq),
        .gpio_in_i   (pins),
        .gpio_out_o  (gout),
        .gpio_oe_o   (goe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Level pins mirror "input matches polarity"; edge pins keep their flag
    function automatic void refresh();
        m_ip = (m_ip & m_type) | (~m_type & ~m_dir & ~(m_pins ^ m_pol));
    endfunction

    function automatic void model_reset();
        m_out = '0; m_dir = '0; m_ie = '0; m_ip = '0; m_type = '0;
        m_pol = '0; m_both = '0; m_db_en = '0; m_presc = '0;
        refresh();
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [15:0] d);
        refresh();
        case (a)
            8'h04: m_out = d;
            8'h08: m_out = m_out | d;
            8'h0C: m_out = m_out & ~d;
            8'h10: m_out = m_out ^ d;
            8'h14: m_dir = d;
            8'h18: m_ie = d;
            8'h1C: m_ip = m_ip & ~d;
            8'h20: m_type = d;
            8'h24: m_pol = d;
            8'h28: m_both = d;
            8'h2C: m_db_en = d;
            8'h30: m_presc = d;
            default: ;
        endcase
        refresh();
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00: return {16'h0, m_pins};
            8'h04: return {16'h0, m_out};
            8'h14: return {16'h0, m_dir};
            8'h18: return {16'h0, m_ie};
            8'h1C: return {16'h0, m_ip};
            8'h20: return {16'h0, m_type};
            8'h24: return {16'h0, m_pol};
            8'h28: return {16'h0, m_both};
            8'h2C: return {16'h0, m_db_en};
            8'h30: return {16'h0, m_presc};
            default: return 32'h0;
        endcase
    endfunction

    // A settled pin change: input edge pins latch a flag when the new level
    // matches their polarity (or on any change with INT_BOTH)
    function automatic void model_pins(input logic [15:0] nv);
        for (int i = 0; i < 16; i++) begin
            if (!m_dir[i] && m_type[i] && nv[i] != m_pins[i]) begin
                if (m_both[i] || nv[i] == m_pol[i]) m_ip[i] = 1'b1;
            end
        end
        m_pins = nv;
        refresh();
    endfunction

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic we);
        d2p.addr = a; d2p.w_data = d; d2p.w_en = we; d2p.req = 1'b1; sel = 1'b1;
        if (we) begin
            exp_q.push_back(32'h0);
            model_write(a[7:0], d[15:0]);
        end else begin
            exp_q.push_back(model_read(a[7:0]));
        end
    endtask

    task automatic drop_req();
        d2p.req = 1'b0; d2p.w_en = 1'b0; sel = 1'b0;
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic we);
        @(negedge clk);
        drive_req(a, d, we);
        @(negedge clk);
        drop_req();
    endtask

    task automatic set_pins(input logic [15:0] nv);
        @(negedge clk);
        pins = nv;
        repeat (5) @(negedge clk);
        model_pins(nv);
    endtask

    // Monitor: every ack pops one expected read value; r_data idles at zero
    always @(negedge clk) begin
        if (!rst) begin
            if (p2d.ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'h1, 32'h0);
                end else begin
                    chk("rdata", p2d.r_data, exp_q.pop_front());
                end
            end else begin
                chk("rdata_idle", p2d.r_data, 32'h0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  a8;
        logic [15:0] nv;
        int          idx;
        logic        we;

        rst = 1'b1; sel = 1'b0; pins = '0; d2p = '0;
        m_pins = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_out", {16'h0, gout}, 32'h0);
        chk("reset_oe", {16'h0, goe}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_ack", {31'h0, p2d.ack}, 32'h0);
        for (int i = 0; i <= 12; i++) bus(i * 4, 32'h0, 1'b0);

        // Atomic output updates
        bus(32'h14, 32'h00FF, 1'b1);
        bus(32'h04, 32'h0055, 1'b1);
        bus(32'h10, 32'h000F, 1'b1);
        bus(32'h0C, 32'h0001, 1'b1);
        bus(32'h04, 32'h0, 1'b0);
        chk("tgl_clr_out", {16'h0, gout}, 32'h005A);
        chk("dir_oe", {16'h0, goe}, 32'h00FF);

        // Rising-edge interrupt on pin 3 with exact latency
        bus(32'h14, 32'h0, 1'b1);
        bus(32'h24, 32'h0008, 1'b1);
        bus(32'h20, 32'h0008, 1'b1);
        bus(32'h1C, 32'hFFFF, 1'b1);
        bus(32'h18, 32'h0008, 1'b1);
        @(negedge clk);
        chk("edge_irq_idle", {31'h0, irq}, 32'h0);
        pins[3] = 1'b1;
        @(negedge clk); chk("edge_irq_c1", {31'h0, irq}, 32'h0);
        @(negedge clk); chk("edge_irq_c2", {31'h0, irq}, 32'h0);
        @(negedge clk); chk("edge_irq_c3", {31'h0, irq}, 32'h1);
        model_pins(pins);
        bus(32'h1C, 32'h0008, 1'b1);
        chk("edge_w1c", {31'h0, irq}, 32'h0);
        set_pins(16'h0000);
        // New edge lands in the same cycle as the W1C: set wins
        @(negedge clk); pins[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("edge_pre_race", {31'h0, irq}, 32'h0);
        drive_req(32'h1C, 32'h0008, 1'b1);
        model_pins(pins);
        @(negedge clk);
        drop_req();
        chk("edge_set_wins", {31'h0, irq}, 32'h1);
        bus(32'h1C, 32'h0, 1'b0);

        // Level-low interrupt on pin 5
        bus(32'h20, 32'h0, 1'b1);
        bus(32'h24, 32'h0, 1'b1);
        bus(32'h18, 32'h0020, 1'b1);
        @(negedge clk); chk("level_irq", {31'h0, irq}, 32'h1);
        bus(32'h1C, 32'h0020, 1'b1);
        @(negedge clk); chk("level_w1c", {31'h0, irq}, 32'h1);
        bus(32'h1C, 32'h0, 1'b0);
        @(negedge clk); pins[5] = 1'b1;
        @(negedge clk); chk("level_c1", {31'h0, irq}, 32'h1);
        @(negedge clk); chk("level_c2", {31'h0, irq}, 32'h1);
        @(negedge clk); chk("level_c3", {31'h0, irq}, 32'h0);
        repeat (3) @(negedge clk);
        model_pins(pins);

        // Randomized register and pin traffic, debounce kept off
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom();
                nv = r[15:0];
                set_pins(nv);
            end else begin
                idx = $urandom_range(0, 15);
                a8 = (idx < 13) ? 8'(idx * 4) : (idx == 13) ? 8'h34 : (idx == 14) ? 8'h40 : 8'hFC;
                r = $urandom();
                we = 1'($urandom_range(0, 1));
                bus({r[31:8], a8}, (a8 == 8'h2C) ? 32'h0 : $urandom(), we);
            end
            @(negedge clk);
            chk("rand_irq", {31'h0, irq}, {31'h0, |(m_ie & m_ip)});
            chk("rand_out", {16'h0, gout}, {16'h0, m_out});
            chk("rand_oe", {16'h0, goe}, {16'h0, m_dir});
        end

        // Debounce on pin 0 with DB_PRESC=9
        bus(32'h18, 32'h0, 1'b1);
        set_pins(16'h0000);
        bus(32'h30, 32'h9, 1'b1);
        repeat (30) @(negedge clk);
        bus(32'h2C, 32'h1, 1'b1);
        @(negedge clk); pins[0] = 1'b1;
        repeat (5) @(negedge clk);
        pins[0] = 1'b0;
        repeat (30) @(negedge clk);
        bus(32'h00, 32'h0, 1'b0);
        @(negedge clk); pins[0] = 1'b1;
        repeat (24) @(negedge clk);
        model_pins(pins);
        bus(32'h00, 32'h0, 1'b0);
        bus(32'h2C, 32'h0, 1'b1);

        // Unmapped read, then a write held through two ack pulses
        bus(32'h40, 32'h0, 1'b0);
        @(negedge clk);
        drive_req(32'h04, 32'h1234, 1'b1);
        exp_q.push_back(32'h0);
        @(negedge clk); chk("hold_ack1", {31'h0, p2d.ack}, 32'h1);
        @(negedge clk); chk("hold_ack2", {31'h0, p2d.ack}, 32'h0);
        @(negedge clk); chk("hold_ack3", {31'h0, p2d.ack}, 32'h1);
        @(negedge clk); chk("hold_ack4", {31'h0, p2d.ack}, 32'h0);
        drop_req();
        chk("hold_out", {16'h0, gout}, 32'h1234);

        // Output pin with INT_BOTH: toggles must not raise IP
        bus(32'h14, 32'h0004, 1'b1);
        bus(32'h20, 32'h0004, 1'b1);
        bus(32'h28, 32'h0004, 1'b1);
        bus(32'h1C, 32'hFFFF, 1'b1);
        for (int t = 0; t < 3; t++) set_pins(pins ^ 16'h0004);
        bus(32'h1C, 32'h0, 1'b0);

        // Reset during a write: no ack, write lost
        @(negedge clk);
        d2p.addr = 32'h04; d2p.w_data = 32'hABCD; d2p.w_en = 1'b1; d2p.req = 1'b1;
        sel = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack", {31'h0, p2d.ack}, 32'h0);
        chk("rst_mid_out", {16'h0, gout}, 32'h0);
        drop_req();
        rst = 1'b0;
        model_reset();
        bus(32'h04, 32'h0, 1'b0);
        bus(32'h14, 32'h0, 1'b0);

        repeat (4) @(negedge clk);
        chk("pending_acks", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
